// File: rtl/led_racer_pkg.sv
// ---------------------------------------------------------------------------
// led_racer_pkg
// Shared definitions for the LED racer strip path: frame-scheduler state
// encoding, pixel width, and the {G,R,B} packing helper used wherever an
// RGB triple becomes a serializer word.
// ---------------------------------------------------------------------------
package led_racer_pkg;

    localparam int PIXEL_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    // WS2812 parts shift green first, so G occupies the top byte.
    function automatic logic [PIXEL_W-1:0] pack_grb(input logic [7:0] g,
                                                    input logic [7:0] r,
                                                    input logic [7:0] b);
        return {g, r, b};
    endfunction

endpackage

// File: rtl/led_latch_timer.sv
// ---------------------------------------------------------------------------
// led_latch_timer
// Load / count-down timer. A load pulse starts a run; expired is high in the
// COUNT-th cycle after the load edge, and the run then stops by itself.
// Ports:
//   clk      in  1  rising-edge clock
//   rst_n    in  1  asynchronous active-low reset
//   load     in  1  start (or restart) a run of COUNT cycles
//   expired  out 1  high during the last cycle of the run
// ---------------------------------------------------------------------------
module led_latch_timer #(
    parameter int COUNT = 2500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expired
);

    localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;

    logic [CW-1:0] cnt;
    logic          running;

    // Loading COUNT-1 makes the zero-count cycle the COUNT-th one of the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (load) begin
            cnt     <= CW'(COUNT - 1);
            running <= 1'b1;
        end else if (running) begin
            if (cnt == '0) begin
                running <= 1'b0;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign expired = running && (cnt == '0);

endmodule

// File: rtl/led_frame_scheduler.sv
// ---------------------------------------------------------------------------
// led_frame_scheduler
// Sequences one LED-strip frame: sweeps current_led over the strip, captures
// the core's intensities, hands each pixel to the serializer, then holds the
// latch gap before returning to idle.
// Ports:
//   clk, rst_n            clock / asynchronous active-low reset
//   update_frame          in   frame request (level, sampled every clock)
//   led_*_intensity       in   8-bit G/R/B for current_led
//   current_led           out  pixel index presented to the core
//   pixel_data            out  {G,R,B} word for the serializer
//   pixel_valid           out  pixel_data offered to the serializer
//   pixel_ready           in   serializer accepts pixel_data this cycle
//   latch_active          out  strip latch gap in progress
//   frame_done            out  one-cycle pulse when the latch gap ends
//   busy                  out  high outside IDLE
// Handshake: a pixel moves only on a clock edge where pixel_valid and
// pixel_ready are both high; while pixel_valid is high, pixel_data and
// current_led hold; pixel_ready without pixel_valid has no effect.
// ---------------------------------------------------------------------------
module led_frame_scheduler
    import led_racer_pkg::*;
#(
    parameter int MAX_POS         = 16,
    parameter int FETCH_LATENCY   = 1,
    parameter int LATCH_CLK_COUNT = 2500
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     update_frame,
    input  logic [7:0]                               led_green_intensity,
    input  logic [7:0]                               led_red_intensity,
    input  logic [7:0]                               led_blue_intensity,
    output logic [((MAX_POS > 1) ? $clog2(MAX_POS) : 1)-1:0] current_led,
    output logic [PIXEL_W-1:0]                       pixel_data,
    output logic                                     pixel_valid,
    input  logic                                     pixel_ready,
    output logic                                     latch_active,
    output logic                                     frame_done,
    output logic                                     busy
);

    localparam int LED_W = (MAX_POS > 1) ? $clog2(MAX_POS) : 1;
    localparam int FW    = (FETCH_LATENCY > 1) ? $clog2(FETCH_LATENCY) : 1;

    state_t        state;
    logic [FW-1:0] fetch_cnt;
    logic          pending;
    logic          last_led;
    logic          latch_load;
    logic          latch_expired;

    assign last_led   = (current_led == LED_W'(MAX_POS - 1));
    // The timer starts on the same edge the FSM enters LATCH.
    assign latch_load = (state == ST_SEND) && pixel_ready && last_led;

    led_latch_timer #(
        .COUNT(LATCH_CLK_COUNT)
    ) u_latch_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (latch_load),
        .expired(latch_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            current_led  <= '0;
            fetch_cnt    <= '0;
            pending      <= 1'b0;
            pixel_data   <= '0;
            pixel_valid  <= 1'b0;
            latch_active <= 1'b0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // Requests arriving mid-frame collapse into one pending refresh.
            if (state != ST_IDLE && update_frame) begin
                pending <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    pending <= 1'b0;
                    if (update_frame || pending) begin
                        state       <= ST_FETCH;
                        current_led <= '0;
                        fetch_cnt   <= '0;
                        busy        <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (fetch_cnt == FW'(FETCH_LATENCY - 1)) begin
                        fetch_cnt   <= '0;
                        pixel_data  <= pack_grb(led_green_intensity,
                                                led_red_intensity,
                                                led_blue_intensity);
                        pixel_valid <= 1'b1;
                        state       <= ST_SEND;
                    end else begin
                        fetch_cnt <= fetch_cnt + FW'(1);
                    end
                end
                ST_SEND: begin
                    if (pixel_ready) begin
                        pixel_valid <= 1'b0;
                        if (last_led) begin
                            current_led  <= '0;
                            latch_active <= 1'b1;
                            state        <= ST_LATCH;
                        end else begin
                            current_led <= current_led + LED_W'(1);
                            state       <= ST_FETCH;
                        end
                    end
                end
                ST_LATCH: begin
                    if (latch_expired) begin
                        latch_active <= 1'b0;
                        frame_done   <= 1'b1;
                        busy         <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_led_frame_scheduler
// Directed bench for led_frame_scheduler with MAX_POS=4, FETCH_LATENCY=1,
// LATCH_CLK_COUNT=8. Expected pixels come from the bench's intensity table
// as whole-frame transactions; a per-cycle monitor compares the offered
// pixel, latch gap length and frame_done placement against them.
// ---------------------------------------------------------------------------
module tb_led_frame_scheduler;

    localparam int MAX_POS         = 4;
    localparam int FETCH_LATENCY   = 1;
    localparam int LATCH_CLK_COUNT = 8;
    localparam int LW              = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          update_frame;
    logic [7:0]    led_green_intensity;
    logic [7:0]    led_red_intensity;
    logic [7:0]    led_blue_intensity;
    logic [LW-1:0] current_led;
    logic [23:0]   pixel_data;
    logic          pixel_valid;
    logic          pixel_ready;
    logic          latch_active;
    logic          frame_done;
    logic          busy;

    // clock / reset block
    always #5 clk = ~clk;

    led_frame_scheduler #(
        .MAX_POS        (MAX_POS),
        .FETCH_LATENCY  (FETCH_LATENCY),
        .LATCH_CLK_COUNT(LATCH_CLK_COUNT)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .update_frame       (update_frame),
        .led_green_intensity(led_green_intensity),
        .led_red_intensity  (led_red_intensity),
        .led_blue_intensity (led_blue_intensity),
        .current_led        (current_led),
        .pixel_data         (pixel_data),
        .pixel_valid        (pixel_valid),
        .pixel_ready        (pixel_ready),
        .latch_active       (latch_active),
        .frame_done         (frame_done),
        .busy               (busy)
    );

    // Core model: intensities looked up by the index the DUT presents.
    logic [23:0] pix_tab [MAX_POS];
    assign led_green_intensity = pix_tab[current_led][23:16];
    assign led_red_intensity   = pix_tab[current_led][15:8];
    assign led_blue_intensity  = pix_tab[current_led][7:0];

    int errors      = 0;
    int checks      = 0;
    int exp_frames  = 0;
    int frames_seen = 0;
    logic [LW+23:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // ---- driver tasks ----
    task automatic push_frame();
        for (int i = 0; i < MAX_POS; i++) begin
            exp_q.push_back({LW'(i), pix_tab[i]});
        end
        exp_frames++;
    endtask

    task automatic pulse_update();
        update_frame = 1'b1;
        @(posedge clk); #1;
        update_frame = 1'b0;
    endtask

    task automatic wait_send(input int led);
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (pixel_valid && current_led == LW'(led)) return;
        end
        timeout("wait_send");
    endtask

    task automatic wait_done();
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (frame_done) return;
        end
        timeout("wait_done");
    endtask

    task automatic wait_latch();
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (latch_active) return;
        end
        timeout("wait_latch");
    endtask

    task automatic expect_idle_for(input string name, input int cycles);
        int busy_seen;
        busy_seen = 0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk); #1;
            if (busy) busy_seen++;
        end
        check(name, busy_seen, 0);
    endtask

    // ---- scoreboard / monitor ----
    logic [LW+23:0] head;
    logic           prev_latch;
    int             latch_run;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_latch = 1'b0;
            latch_run  = 0;
        end else begin
            if (pixel_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: led %0d data %06h with nothing expected",
                             current_led, pixel_data);
                end else begin
                    head = exp_q[0];
                    check("pixel_led", current_led, head[LW+23:24]);
                    check("pixel_data", pixel_data, head[23:0]);
                    if (pixel_ready) void'(exp_q.pop_front());
                end
            end
            if (pixel_valid || latch_active) check("busy_flag", busy, 1);
            if (latch_active) begin
                latch_run++;
            end else if (latch_run != 0) begin
                check("latch_len", latch_run, LATCH_CLK_COUNT);
                latch_run = 0;
            end
            if (frame_done) begin
                frames_seen++;
                check("done_after_latch", {prev_latch, latch_active, busy}, 3'b100);
            end
            prev_latch = latch_active;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---- directed sequence ----
    initial begin
        int  cycles;
        bit  seen_led1;
        bit  seen_latch;

        rst_n        = 1'b0;
        update_frame = 1'b0;
        pixel_ready  = 1'b1;
        pix_tab[0] = 24'h010203;
        pix_tab[1] = 24'h123456;
        pix_tab[2] = 24'h7F80FF;
        pix_tab[3] = 24'hC0FFEE;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {current_led, pixel_data, pixel_valid, latch_active, frame_done, busy}, 0);
        rst_n = 1'b1;
        expect_idle_for("idle_no_request", 5);

        // Frame A: ready tied high, length, packing, wrap.
        push_frame();
        update_frame = 1'b1;
        @(posedge clk); #1;
        update_frame = 1'b0;
        check("busy_after_request", busy, 1);
        cycles = 1;
        seen_led1 = 1'b0;
        seen_latch = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            cycles++;
            if (pixel_valid && current_led == 2'd1 && !seen_led1) begin
                seen_led1 = 1'b1;
                check("pack_led1", pixel_data, 24'h123456);
                pix_tab[1] = 24'hABCDEF;
            end
            if (latch_active && !seen_latch) begin
                seen_latch = 1'b1;
                check("wrap_led", current_led, 0);
            end
            if (frame_done) break;
        end
        check("frame_len", cycles, 17);
        check("idle_at_done", busy, 0);

        // Frame B: back-pressure on pixel 2.
        push_frame();
        pulse_update();
        wait_send(2);
        pixel_ready = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("stall_valid", pixel_valid, 1);
        check("stall_led", current_led, 2);
        check("stall_data", pixel_data, 24'h7F80FF);
        pixel_ready = 1'b1;
        @(posedge clk); #1;
        check("valid_drop", pixel_valid, 0);
        wait_done();

        // Frames C+D: three mid-frame requests give one extra frame.
        push_frame();
        push_frame();
        pulse_update();
        wait_send(1);
        pulse_update();
        wait_send(3);
        pulse_update();
        wait_latch();
        pulse_update();
        wait_done();
        check("idle_at_done_c", busy, 0);
        @(posedge clk); #1;
        check("pending_restart", busy, 1);
        wait_done();
        expect_idle_for("no_extra_frame", 30);

        // Frames E+F: request during the frame_done cycle.
        push_frame();
        push_frame();
        pulse_update();
        wait_done();
        update_frame = 1'b1;
        @(posedge clk); #1;
        update_frame = 1'b0;
        check("done_cycle_restart", busy, 1);
        wait_done();
        expect_idle_for("no_extra_frame_e", 30);

        check("all_pixels_sent", exp_q.size(), 0);
        check("frame_count", frames_seen, exp_frames);

        // Reset in the middle of SEND with the pixel held.
        exp_q.push_back({LW'(0), pix_tab[0]});
        pixel_ready = 1'b0;
        pulse_update();
        wait_send(0);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_send", {current_led, pixel_data, pixel_valid, latch_active, frame_done, busy}, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        pixel_ready = 1'b1;
        expect_idle_for("idle_after_reset", 30);
        check("frame_count_final", frames_seen, exp_frames);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
